// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop RX synchronizer, mid-bit sampling FSM,
// sticky rdy/frm_err flags and a registered received byte.
`timescale 1ns/1ps
module uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam int CW   = $clog2(BAUD_DIV);
  localparam int HALF = BAUD_DIV >> 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RCV  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rdy_q, rdy_d;
  logic          frm_err_q, frm_err_d;
  logic          sample_s;

  // RX synchronizer, preset to the idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rdy_q      <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // Next-state logic; flag sets are written after clr_rdy so a set wins
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rdy_d      = rdy_q;
    frm_err_d  = frm_err_q;
    sample_s   = 1'b0;

    if (clr_rdy) begin
      rdy_d     = 1'b0;
      frm_err_d = 1'b0;
    end else begin
      rdy_d     = rdy_q;
      frm_err_d = frm_err_q;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d    = RCV;
          baud_cnt_d = '0;
          bit_cnt_d  = 4'd0;
          rdy_d      = 1'b0;
          frm_err_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RCV: begin
        // start bit is sampled half a bit in, the rest one full bit apart
        if (bit_cnt_q == 4'd0) begin
          sample_s = (baud_cnt_q == HALF_M1);
        end else begin
          sample_s = (baud_cnt_q == FULL_M1);
        end
        if (sample_s) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 4'd0) begin
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              bit_cnt_d = 4'd1;
            end
          end else if (bit_cnt_q == 4'd9) begin
            state_d = IDLE;
            if (rx_s_q) begin
              rx_data_d = shift_q;
              rdy_d     = 1'b1;
            end else begin
              frm_err_d = 1'b1;
            end
          end else begin
            shift_d   = {rx_s_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-written corner
// sequences and randomized frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BD   = 16;
  localparam int HALF = BD / 2;
  localparam int S    = 2 + HALF + 9 * BD;  // edges from start fall to sample 9

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] prev_data_e;
  logic       prev_rdy_e;

  always #5 clk = ~clk;

  uart_rx #(.BAUD_DIV(BD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         scale;     // sender bit period in per-mille of BD
    int         gap;
    logic       clr_hold;
    logic       exp_rdy;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // index of the bit the sender is transmitting c cycles into the frame
  function automatic int bit_at(input int c, input int scale);
    int i;
    i = 0;
    while (i < 9 && ((i + 1) * BD * scale) / 1000 <= c) i++;
    return i;
  endfunction

  // Drive one frame starting at the current negedge and check the outputs at
  // the cycles the receiver timing rules single out.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int scale,
                            input logic clr_hold, input logic exp_rdy,
                            input logic exp_err, input logic [7:0] exp_data);
    logic [9:0] bits;
    int tot;
    int pos;
    bits = {stop, d, 1'b0};
    tot  = (10 * BD * scale) / 1000;
    for (int c = 0; c < tot; c++) begin
      RX      = bits[bit_at(c, scale)];
      clr_rdy = clr_hold && (c >= S - 4) && (c <= S + 1);
      @(negedge clk);
      pos = c + 1;
      if (pos == 2) chk("rdy_before_detect", {31'd0, rdy}, {31'd0, prev_rdy_e});
      if (pos == 3) begin
        chk("rdy_at_detect", {31'd0, rdy}, 32'd0);
        chk("err_at_detect", {31'd0, frm_err}, 32'd0);
      end
      if (pos == S) begin
        chk("rdy_before_s9", {31'd0, rdy}, 32'd0);
        chk("data_before_s9", {24'd0, rx_data}, {24'd0, prev_data_e});
      end
      if (pos == S + 1) begin
        chk("rdy_at_s9", {31'd0, rdy}, {31'd0, exp_rdy});
        chk("err_at_s9", {31'd0, frm_err}, {31'd0, exp_err});
        chk("data_at_s9", {24'd0, rx_data}, {24'd0, exp_data});
      end
      if (clr_hold && pos == S + 2) chk("rdy_after_clr", {31'd0, rdy}, 32'd0);
    end
    RX      = 1'b1;
    clr_rdy = 1'b0;
  endtask

  initial begin
    logic [9:0] rbits;
    logic [7:0] d;
    logic       stop;
    int         scale;
    int         gap;
    logic [7:0] exp_data;
    int         glen[3];

    RX      = 1'b1;
    clr_rdy = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rdy", {31'd0, rdy}, 32'd0);
    chk("reset_err", {31'd0, frm_err}, 32'd0);
    chk("reset_data", {24'd0, rx_data}, 32'd0);
    rst_n = 1'b1;
    idle(4);
    prev_rdy_e  = 1'b0;
    prev_data_e = 8'h00;

    vecs[0] = '{8'h67, 1'b1, 1000, 4,  1'b0, 1'b1, 1'b0, 8'h67};
    vecs[1] = '{8'hA5, 1'b1, 1000, 0,  1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[2] = '{8'h3C, 1'b1, 1000, 3,  1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[3] = '{8'h12, 1'b1, 1000, 2,  1'b0, 1'b1, 1'b0, 8'h12};
    vecs[4] = '{8'hFF, 1'b0, 1000, BD, 1'b0, 1'b0, 1'b1, 8'h12};
    vecs[5] = '{8'h81, 1'b1, 1000, 3,  1'b1, 1'b1, 1'b0, 8'h81};
    vecs[6] = '{8'h55, 1'b1, 985,  0,  1'b0, 1'b1, 1'b0, 8'h55};
    vecs[7] = '{8'h0F, 1'b1, 1015, 4,  1'b0, 1'b1, 1'b0, 8'h0F};

    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].scale, vecs[v].clr_hold,
                 vecs[v].exp_rdy, vecs[v].exp_err, vecs[v].exp_data);
      prev_rdy_e  = vecs[v].exp_rdy && !vecs[v].clr_hold;
      prev_data_e = vecs[v].exp_data;
      idle(vecs[v].gap);
    end

    // single-cycle acknowledge
    chk("rdy_before_ack", {31'd0, rdy}, 32'd1);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    chk("rdy_after_ack", {31'd0, rdy}, 32'd0);
    chk("data_after_ack", {24'd0, rx_data}, 32'h0F);
    prev_rdy_e = 1'b0;

    // short low pulses are false starts
    glen[0] = 1;
    glen[1] = HALF / 2;
    glen[2] = HALF - 1;
    for (int g = 0; g < 3; g++) begin
      RX = 1'b0;
      repeat (glen[g]) @(negedge clk);
      idle(HALF + 8);
      chk("glitch_rdy", {31'd0, rdy}, 32'd0);
      chk("glitch_err", {31'd0, frm_err}, 32'd0);
      chk("glitch_data", {24'd0, rx_data}, 32'h0F);
    end
    send_frame(8'h55, 1'b1, 1000, 1'b0, 1'b1, 1'b0, 8'h55);
    prev_rdy_e  = 1'b1;
    prev_data_e = 8'h55;
    idle(3);

    // reset in the middle of data bit 4, held until the frame has passed
    rbits = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = rbits[i];
      for (int j = 0; j < BD; j++) begin
        if (i == 5 && j == HALF) begin
          rst_n = 1'b0;
          #1;
          chk("async_rst_data", {24'd0, rx_data}, 32'd0);
          chk("async_rst_rdy", {31'd0, rdy}, 32'd0);
          chk("async_rst_err", {31'd0, frm_err}, 32'd0);
        end
        @(negedge clk);
      end
    end
    idle(3);
    rst_n = 1'b1;
    idle(2 * BD);
    chk("post_rst_rdy", {31'd0, rdy}, 32'd0);
    chk("post_rst_data", {24'd0, rx_data}, 32'd0);
    prev_rdy_e  = 1'b0;
    prev_data_e = 8'h00;
    send_frame(8'h0F, 1'b1, 1000, 1'b0, 1'b1, 1'b0, 8'h0F);
    prev_rdy_e  = 1'b1;
    prev_data_e = 8'h0F;
    idle(2);

    // randomized frames: frame-level model keeps the last good byte
    for (int n = 0; n < 30; n++) begin
      d        = 8'($urandom);
      stop     = ($urandom_range(0, 4) != 0);
      scale    = stop ? (980 + int'($urandom_range(0, 40))) : 1000;
      gap      = stop ? int'($urandom_range(0, 3)) : BD;
      exp_data = stop ? d : prev_data_e;
      send_frame(d, stop, scale, 1'b0, stop, !stop, exp_data);
      prev_rdy_e  = stop;
      prev_data_e = exp_data;
      idle(gap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
